regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_pkg.sv | 21 ++
 rtl/regfile_write_arbiter_rr_arbiter2.sv | 41 ++++
 rtl/regfile_write_arbiter.sv | 149 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_pkg
// Shared definitions for the register-file writeback arbiter: default data and
// address widths, requester index constants and the round-robin pointer type.
// -----------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    // Requester indices; also the bit positions in the valid/grant vectors.
    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;

    // Points at the requester that wins the next contended cycle.
    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LD  = 1'b1
    } rr_ptr_t;

endpackage : regfile_write_arbiter_pkg

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant logic, purely combinational. A lone requester is
// granted without moving the pointer; under contention the pointed-to requester
// wins and the next pointer moves to the other one.
//
// Ports
//   valid_i    [1:0]  request vector, bit REQ_ALU / REQ_LD
//   ptr_i             current priority pointer
//   gnt_o      [1:0]  one-hot grant (all zero when nothing is valid)
//   ptr_nxt_o         pointer value to register for the next cycle
// -----------------------------------------------------------------------------
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic [1:0] valid_i,
    input  rr_ptr_t    ptr_i,
    output logic [1:0] gnt_o,
    output rr_ptr_t    ptr_nxt_o
);

    always_comb begin
        gnt_o     = 2'b00;
        ptr_nxt_o = ptr_i;
        unique case (valid_i)
            2'b01: gnt_o[REQ_ALU] = 1'b1;
            2'b10: gnt_o[REQ_LD]  = 1'b1;
            2'b11: begin
                if (ptr_i == RR_ALU) begin
                    gnt_o[REQ_ALU] = 1'b1;
                    ptr_nxt_o      = RR_LD;
                end else begin
                    gnt_o[REQ_LD]  = 1'b1;
                    ptr_nxt_o      = RR_ALU;
                end
            end
            default: ;
        endcase
    end

endmodule : rr_arbiter2

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Arbitrates ALU and load writebacks onto a single register-file write port
// (1-cycle latency), tracks pending destination registers in a scoreboard and
// raises stall when an issuing source operand is still pending.
//
// Optional feature: define REGFILE_WB_BYPASS_EN to forward the committing
// write (A3/WD3) to matching source operands and suppress their stall.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   alu_valid/alu_ready, alu_rd,    ALU writeback handshake (requester 0)
//   alu_data
//   ld_valid/ld_ready, ld_rd,       load writeback handshake (requester 1)
//   ld_data
//   rsv_valid, rsv_rd               issue stage marks rsv_rd pending
//   rs1, rs2                        source operands being issued
//   stall                           source operand hazard
//   fwd1_valid/fwd1_data,           bypass results for rs1 / rs2
//   fwd2_valid/fwd2_data
//   A3, WD3, RegWrite               register-file write port
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int XLEN = regfile_write_arbiter_pkg::XLEN,
    parameter int AW   = regfile_write_arbiter_pkg::AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            stall,
    output logic            fwd1_valid,
    output logic [XLEN-1:0] fwd1_data,
    output logic            fwd2_valid,
    output logic [XLEN-1:0] fwd2_data,
    output logic [AW-1:0]   A3,
    output logic [XLEN-1:0] WD3,
    output logic            RegWrite
);

    import regfile_write_arbiter_pkg::*;

    localparam int NREG = 1 << AW;

    rr_ptr_t         rr_ptr_q, rr_ptr_d;
    logic            regwrite_q, regwrite_d;
    logic [AW-1:0]   a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic [1:0]      req_valid;
    logic [1:0]      gnt;
    logic            xfer;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;
    logic            bypass1, bypass2;

    // Requests are masked during reset so neither ready can rise.
    assign req_valid = {ld_valid, alu_valid} & {2{~reset}};

    rr_arbiter2 u_rr_arbiter2 (
        .valid_i   (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .ptr_nxt_o (rr_ptr_d)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign ld_ready  = gnt[REQ_LD];
    assign xfer      = |gnt;
    assign win_rd    = gnt[REQ_LD] ? ld_rd   : alu_rd;
    assign win_data  = gnt[REQ_LD] ? ld_data : alu_data;

    // Writes to x0 are accepted but never committed; A3/WD3 keep their last
    // committed values so the port only ever shows real writes.
    always_comb begin
        regwrite_d = xfer && (win_rd != '0);
        a3_d       = a3_q;
        wd3_d      = wd3_q;
        if (regwrite_d) begin
            a3_d  = win_rd;
            wd3_d = win_data;
        end
    end

    // Reset gates the port combinationally so a write accepted just before
    // reset asserts is dropped in its commit cycle.
    assign RegWrite = regwrite_q & ~reset;
    assign A3       = reset ? '0 : a3_q;
    assign WD3      = reset ? '0 : wd3_q;

    // Set after clear: a new reservation wins over a same-cycle commit.
    always_comb begin
        pending_d = pending_q;
        if (RegWrite) begin
            pending_d[A3] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != '0)) begin
            pending_d[rsv_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= RR_ALU;
            regwrite_q <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
            pending_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            regwrite_q <= regwrite_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
            pending_q  <= pending_d;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign bypass1    = RegWrite && (A3 == rs1) && (rs1 != '0);
    assign bypass2    = RegWrite && (A3 == rs2) && (rs2 != '0);
    assign fwd1_valid = bypass1;
    assign fwd2_valid = bypass2;
    assign fwd1_data  = bypass1 ? WD3 : '0;
    assign fwd2_data  = bypass2 ? WD3 : '0;
`else
    assign bypass1    = 1'b0;
    assign bypass2    = 1'b0;
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
`endif

    assign stall = ((rs1 != '0) && pending_q[rs1] && !bypass1) ||
                   ((rs2 != '0) && pending_q[rs2] && !bypass2);

endmodule : regfile_write_arbiter

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic [4:0]  rs1, rs2;
    logic        stall;
    logic        fwd1_valid, fwd2_valid;
    logic [31:0] fwd1_data, fwd2_data;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        RegWrite;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t mon_e;

`ifdef REGFILE_WB_BYPASS_EN
    localparam logic        BYP        = 1'b1;
`else
    localparam logic        BYP        = 1'b0;
`endif

    regfile_write_arbiter #(.XLEN(32), .AW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .rsv_valid  (rsv_valid),
        .rsv_rd     (rsv_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .stall      (stall),
        .fwd1_valid (fwd1_valid),
        .fwd1_data  (fwd1_data),
        .fwd2_valid (fwd2_valid),
        .fwd2_data  (fwd2_data),
        .A3         (A3),
        .WD3        (WD3),
        .RegWrite   (RegWrite)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every commit on the write port must match the next queued write.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: actual A3=%0d WD3=0x%0h required no write", A3, WD3);
            end else begin
                mon_e = exp_q.pop_front();
                chk32("commit_A3", 32'(A3), 32'(mon_e.rd));
                chk32("commit_WD3", WD3, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] alu_pend[$];
        logic [4:0] ld_pend[$];

        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
        rsv_valid = 1'b0; rsv_rd = '0;
        rs1 = '0; rs2 = '0;

        // Reset: requests presented but must not be granted.
        next_cycle();
        alu_valid = 1'b1; alu_rd = 5'd1;
        ld_valid  = 1'b1; ld_rd  = 5'd11;
        @(negedge clk);
        chk1("rst_alu_ready", alu_ready, 1'b0);
        chk1("rst_ld_ready", ld_ready, 1'b0);
        chk1("rst_regwrite", RegWrite, 1'b0);
        chk32("rst_A3", 32'(A3), 32'd0);
        chk32("rst_WD3", WD3, 32'd0);
        chk1("rst_stall", stall, 1'b0);

        // Dual requests starting in the cycle reset deasserts.
        next_cycle();
        reset = 1'b0;
        alu_pend = '{5'd1, 5'd2, 5'd3, 5'd4};
        ld_pend  = '{5'd11, 5'd12, 5'd13, 5'd14};
        exp_q.push_back('{5'd1,  32'hA000_0001});
        exp_q.push_back('{5'd11, 32'hB000_000B});
        exp_q.push_back('{5'd2,  32'hA000_0002});
        exp_q.push_back('{5'd12, 32'hB000_000C});
        exp_q.push_back('{5'd3,  32'hA000_0003});
        exp_q.push_back('{5'd13, 32'hB000_000D});
        exp_q.push_back('{5'd4,  32'hA000_0004});
        exp_q.push_back('{5'd14, 32'hB000_000E});
        for (int c = 0; c < 20 && (alu_pend.size() > 0 || ld_pend.size() > 0); c++) begin
            alu_valid = (alu_pend.size() > 0);
            ld_valid  = (ld_pend.size() > 0);
            if (alu_valid) begin
                alu_rd   = alu_pend[0];
                alu_data = 32'hA000_0000 + 32'(alu_rd);
            end
            if (ld_valid) begin
                ld_rd   = ld_pend[0];
                ld_data = 32'hB000_0000 + 32'(ld_rd);
            end
            @(negedge clk);
            chk1($sformatf("dual_onehot_c%0d", c), alu_ready ^ ld_ready, 1'b1);
            if (c < 4) chk1($sformatf("dual_grant_alu_c%0d", c), alu_ready, (c % 2) == 0);
            if (alu_ready) void'(alu_pend.pop_front());
            if (ld_ready)  void'(ld_pend.pop_front());
            next_cycle();
        end
        chk1("dual_all_granted", (alu_pend.size() == 0) && (ld_pend.size() == 0), 1'b1);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        next_cycle();
        next_cycle();
        chk32("dual_queue_empty", 32'(exp_q.size()), 32'd0);

        // Single ALU write, latency 1, RegWrite one cycle, port holds.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1("single_alu_ready", alu_ready, 1'b1);
        chk1("single_ld_ready", ld_ready, 1'b0);
        exp_q.push_back('{5'd5, 32'hDEAD_BEEF});
        next_cycle();
        alu_valid = 1'b0;
        @(negedge clk);
        chk1("single_regwrite", RegWrite, 1'b1);
        chk32("single_A3", 32'(A3), 32'd5);
        chk32("single_WD3", WD3, 32'hDEAD_BEEF);
        next_cycle();
        @(negedge clk);
        chk1("single_regwrite_low", RegWrite, 1'b0);
        chk32("hold_A3", 32'(A3), 32'd5);
        chk32("hold_WD3", WD3, 32'hDEAD_BEEF);

        // Reserve 7, stall on rs1 until the commit.
        next_cycle();
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        @(negedge clk);
        next_cycle();
        rsv_valid = 1'b0; rs1 = 5'd7;
        @(negedge clk);
        chk1("rsv7_stall_a", stall, 1'b1);
        next_cycle();
        @(negedge clk);
        chk1("rsv7_stall_b", stall, 1'b1);
        next_cycle();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0000_0077;
        @(negedge clk);
        chk1("rsv7_ld_ready", ld_ready, 1'b1);
        chk1("rsv7_stall_accept", stall, 1'b1);
        exp_q.push_back('{5'd7, 32'h0000_0077});
        next_cycle();
        ld_valid = 1'b0;
        @(negedge clk);
        chk1("rsv7_stall_commit", stall, ~BYP);
        chk1("rsv7_fwd1_valid", fwd1_valid, BYP);
        chk32("rsv7_fwd1_data", fwd1_data, BYP ? 32'h0000_0077 : 32'd0);
        chk1("rsv7_fwd2_valid", fwd2_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("rsv7_stall_after", stall, 1'b0);

        // Load to x0: accepted, never committed.
        next_cycle();
        rs1 = '0; rs2 = 5'd5;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h0000_1234;
        @(negedge clk);
        chk1("x0_ld_ready", ld_ready, 1'b1);
        chk1("x0_alu_ready", alu_ready, 1'b0);
        next_cycle();
        ld_valid = 1'b0;
        @(negedge clk);
        chk1("x0_regwrite", RegWrite, 1'b0);
        chk1("x0_stall", stall, 1'b0);

        // Reservation of 9 in the same cycle as a commit to 9.
        next_cycle();
        rs2 = '0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
        @(negedge clk);
        chk1("r9_alu_ready", alu_ready, 1'b1);
        exp_q.push_back('{5'd9, 32'h0000_0099});
        next_cycle();
        alu_valid = 1'b0;
        rsv_valid = 1'b1; rsv_rd = 5'd9;
        @(negedge clk);
        chk1("r9_commit", RegWrite, 1'b1);
        next_cycle();
        rsv_valid = 1'b0; rs2 = 5'd9;
        @(negedge clk);
        chk1("r9_stall", stall, 1'b1);
        chk1("r9_fwd2_valid", fwd2_valid, 1'b0);
        next_cycle();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0000_0999;
        @(negedge clk);
        exp_q.push_back('{5'd9, 32'h0000_0999});
        next_cycle();
        ld_valid = 1'b0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk1("r9_stall_cleared", stall, 1'b0);

        // Reset in the commit cycle of an accepted write; pointer was left at LD.
        next_cycle();
        rs2 = '0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
        rsv_valid = 1'b1; rsv_rd = 5'd12;
        @(negedge clk);
        chk1("rw_alu_ready", alu_ready, 1'b1);
        next_cycle();
        reset = 1'b1;
        rsv_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA000_0014;
        ld_valid  = 1'b1; ld_rd  = 5'd21; ld_data  = 32'hB000_0015;
        @(negedge clk);
        chk1("rw_regwrite", RegWrite, 1'b0);
        chk32("rw_A3", 32'(A3), 32'd0);
        chk32("rw_WD3", WD3, 32'd0);
        chk1("rw_alu_ready_rst", alu_ready, 1'b0);
        chk1("rw_ld_ready_rst", ld_ready, 1'b0);
        next_cycle();
        reset = 1'b0;
        rs1 = 5'd12;
        @(negedge clk);
        chk1("rw_first_alu", alu_ready, 1'b1);
        chk1("rw_first_ld", ld_ready, 1'b0);
        chk1("rw_pending_clear", stall, 1'b0);
        exp_q.push_back('{5'd20, 32'hA000_0014});
        next_cycle();
        alu_valid = 1'b0;
        @(negedge clk);
        chk1("rw_ld_after", ld_ready, 1'b1);
        exp_q.push_back('{5'd21, 32'hB000_0015});
        next_cycle();
        ld_valid = 1'b0;
        rs1 = '0;
        @(negedge clk);
        next_cycle();
        next_cycle();
        chk32("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regfile_write_arbiter
